// File: rtl/video_pattern_gen.sv
// Video stream source for scaler BIST. Emits do/de/hs/vs frames with programmable
// geometry, blanking and inter-pixel gaps; all outputs are registered from the FSM state.
//
//   state  | meaning
//   IDLE   | stopped, waiting for en with a valid geometry
//   VBLANK | vertical blank before each frame, vblank cycles
//   PIX    | one active pixel (de=1)
//   GAP    | empty cycles after a pixel within a line
//   HBLANK | horizontal blank between lines
module video_pattern_gen #(
    parameter int PIXEL_WIDTH = 8,
    parameter int CNT_WIDTH   = 12,
    parameter int BLANK_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [CNT_WIDTH-1:0]   cfg_w,
    input  logic [CNT_WIDTH-1:0]   cfg_h,
    input  logic [BLANK_WIDTH-1:0] cfg_hblank,
    input  logic [BLANK_WIDTH-1:0] cfg_vblank,
    input  logic [3:0]             cfg_gap,
    input  logic [1:0]             cfg_pattern,
    input  logic [PIXEL_WIDTH-1:0] cfg_const,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   sof_o,
    output logic                   busy_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VBLANK = 3'd1,
        S_PIX    = 3'd2,
        S_GAP    = 3'd3,
        S_HBLANK = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   x_q, x_d;
    logic [CNT_WIDTH-1:0]   y_q, y_d;
    logic [BLANK_WIDTH-1:0] cnt_q, cnt_d;

    logic [CNT_WIDTH-1:0]   w_q, w_d;
    logic [CNT_WIDTH-1:0]   h_q, h_d;
    logic [BLANK_WIDTH-1:0] hblank_q, hblank_d;
    logic [3:0]             gap_q, gap_d;
    logic [1:0]             pattern_q, pattern_d;
    logic [PIXEL_WIDTH-1:0] const_q, const_d;

    logic [PIXEL_WIDTH-1:0] do_q, do_d;
    logic                   de_q, de_d;
    logic                   hs_q, hs_d;
    logic                   vs_q, vs_d;
    logic                   sof_q, sof_d;
    logic                   busy_q, busy_d;

    logic                   cfg_valid;
    logic                   cfg_load;
    logic [BLANK_WIDTH-1:0] vblank_load;
    logic [BLANK_WIDTH-1:0] hblank_load;
    logic                   last_x;
    logic                   last_y;

    // Zero-length blanking is stretched to one cycle; counters hold length-1.
    assign cfg_valid   = (cfg_w != '0) && (cfg_h != '0);
    assign vblank_load = (cfg_vblank == '0) ? '0 : cfg_vblank - BLANK_WIDTH'(1);
    assign hblank_load = (hblank_q == '0) ? '0 : hblank_q - BLANK_WIDTH'(1);
    assign last_x      = (x_q == w_q - CNT_WIDTH'(1));
    assign last_y      = (y_q == h_q - CNT_WIDTH'(1));

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        cfg_load = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en && cfg_valid) begin
                    state_d  = S_VBLANK;
                    cfg_load = 1'b1;
                    cnt_d    = vblank_load;
                end
            end
            S_VBLANK: begin
                if (cnt_q == '0) begin
                    state_d = S_PIX;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    cnt_d = cnt_q - BLANK_WIDTH'(1);
                end
            end
            S_PIX: begin
                if (!last_x) begin
                    if (gap_q != 4'd0) begin
                        state_d = S_GAP;
                        cnt_d   = BLANK_WIDTH'(gap_q - 4'd1);
                    end else begin
                        x_d = x_q + CNT_WIDTH'(1);
                    end
                end else if (!last_y) begin
                    state_d = S_HBLANK;
                    cnt_d   = hblank_load;
                end else if (en && cfg_valid) begin
                    // Back-to-back frame: pick up whatever geometry is now on cfg_*.
                    state_d  = S_VBLANK;
                    cfg_load = 1'b1;
                    cnt_d    = vblank_load;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_PIX;
                    x_d     = x_q + CNT_WIDTH'(1);
                end else begin
                    cnt_d = cnt_q - BLANK_WIDTH'(1);
                end
            end
            S_HBLANK: begin
                if (cnt_q == '0) begin
                    state_d = S_PIX;
                    x_d     = '0;
                    y_d     = y_q + CNT_WIDTH'(1);
                end else begin
                    cnt_d = cnt_q - BLANK_WIDTH'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_d       = w_q;
        h_d       = h_q;
        hblank_d  = hblank_q;
        gap_d     = gap_q;
        pattern_d = pattern_q;
        const_d   = const_q;
        if (cfg_load) begin
            w_d       = cfg_w;
            h_d       = cfg_h;
            hblank_d  = cfg_hblank;
            gap_d     = cfg_gap;
            pattern_d = cfg_pattern;
            const_d   = cfg_const;
        end
    end

    // Output stage follows the current state by one cycle; pattern sums are one bit
    // wider than the counters before truncation to the pixel width.
    always_comb begin
        de_d   = (state_q == S_PIX);
        hs_d   = !((state_q == S_PIX) || (state_q == S_GAP));
        vs_d   = (state_q == S_PIX) || (state_q == S_GAP) || (state_q == S_HBLANK);
        sof_d  = (state_q == S_PIX) && (x_q == '0) && (y_q == '0);
        busy_d = (state_q != S_IDLE);
        do_d   = do_q;
        if (state_q == S_PIX) begin
            case (pattern_q)
                2'd0:    do_d = PIXEL_WIDTH'({1'b0, x_q} + (CNT_WIDTH + 1)'(1));
                2'd1:    do_d = PIXEL_WIDTH'({1'b0, y_q} + (CNT_WIDTH + 1)'(1));
                2'd2:    do_d = PIXEL_WIDTH'({1'b0, x_q} + {1'b0, y_q});
                default: do_d = const_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            w_q       <= '0;
            h_q       <= '0;
            hblank_q  <= '0;
            gap_q     <= '0;
            pattern_q <= '0;
            const_q   <= '0;
            do_q      <= '0;
            de_q      <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b0;
            sof_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            w_q       <= w_d;
            h_q       <= h_d;
            hblank_q  <= hblank_d;
            gap_q     <= gap_d;
            pattern_q <= pattern_d;
            const_q   <= const_d;
            do_q      <= do_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            sof_q     <= sof_d;
            busy_q    <= busy_d;
        end
    end

    assign do_o   = do_q;
    assign de_o   = de_q;
    assign hs_o   = hs_q;
    assign vs_o   = vs_q;
    assign sof_o  = sof_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen: expected pixels queued per frame, popped on de_o.
module tb_video_pattern_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic [11:0] cfg_w;
    logic [11:0] cfg_h;
    logic [11:0] cfg_hblank;
    logic [11:0] cfg_vblank;
    logic [3:0]  cfg_gap;
    logic [1:0]  cfg_pattern;
    logic [7:0]  cfg_const;
    logic [7:0]  do_o;
    logic        de_o;
    logic        hs_o;
    logic        vs_o;
    logic        sof_o;
    logic        busy_o;

    video_pattern_gen #(.PIXEL_WIDTH(8), .CNT_WIDTH(12), .BLANK_WIDTH(12)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_hblank(cfg_hblank), .cfg_vblank(cfg_vblank),
        .cfg_gap(cfg_gap), .cfg_pattern(cfg_pattern), .cfg_const(cfg_const),
        .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .sof_o(sof_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       s;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_pix(input int x, input int y, input int pat,
                                             input logic [7:0] c);
        int v;
        case (pat)
            0:       v = x + 1;
            1:       v = y + 1;
            2:       v = x + y;
            default: v = int'(c);
        endcase
        return v[7:0];
    endfunction

    task automatic push_frame(input int w, input int h, input int pat, input logic [7:0] c);
        exp_t e;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                e.d = model_pix(x, y, pat, c);
                e.s = (x == 0) && (y == 0);
                exp_q.push_back(e);
            end
        end
    endtask

    // Output monitor: runs on the falling edge, away from the active edge.
    int   cyc         = 0;
    int   de_cnt      = 0;
    int   sof_cnt     = 0;
    int   vs_hi_cnt   = 0;
    int   busy_cnt    = 0;
    int   lo_run      = 0;
    int   last_lo_run = 0;
    int   last_de_cyc = 0;
    int   spacing_exp = 0;
    logic spacing_seen = 1'b0;
    logic prev_vs      = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            cyc++;
            if (busy_o) busy_cnt++;
            if (sof_o) sof_cnt++;
            if (vs_o) begin
                vs_hi_cnt++;
                if (!prev_vs) last_lo_run = lo_run;
                lo_run = 0;
            end else begin
                lo_run++;
            end
            prev_vs = vs_o;
            if (de_o) begin
                de_cnt++;
                check("de_outside_active", {30'd0, hs_o, ~vs_o}, 32'd0);
                check("exp_q_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("pixel", {24'd0, do_o}, {24'd0, e.d});
                    check("sof", {31'd0, sof_o}, {31'd0, e.s});
                end
                if (spacing_exp != 0) begin
                    if (spacing_seen) check("de_spacing", cyc - last_de_cyc, spacing_exp);
                    spacing_seen = 1'b1;
                end else begin
                    spacing_seen = 1'b0;
                end
                last_de_cyc = cyc;
            end else if (sof_o) begin
                check("sof_without_de", {31'd0, sof_o}, 32'd0);
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_de(input string tag);
        int n = 0;
        while (!de_o && n < 5000) begin
            tick();
            n++;
        end
        check(tag, {31'd0, de_o}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 10000) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy_o}, 32'd0);
    endtask

    task automatic set_cfg(input int w, input int h, input int gap, input int hb, input int vb,
                           input int pat, input logic [7:0] c);
        cfg_w       = 12'(w);
        cfg_h       = 12'(h);
        cfg_gap     = 4'(gap);
        cfg_hblank  = 12'(hb);
        cfg_vblank  = 12'(vb);
        cfg_pattern = 2'(pat);
        cfg_const   = c;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int de_b, sof_b, vs_b, busy_b, t;

        rst = 1'b1;
        en  = 1'b0;
        set_cfg(4, 2, 0, 3, 2, 0, 8'h00);
        repeat (3) tick();
        check("rst_do",   {24'd0, do_o}, 32'd0);
        check("rst_de",   {31'd0, de_o}, 32'd0);
        check("rst_hs",   {31'd0, hs_o}, 32'd1);
        check("rst_vs",   {31'd0, vs_o}, 32'd0);
        check("rst_sof",  {31'd0, sof_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // T1: basic two-line frame, latency from en to first pixel
        de_b = de_cnt; sof_b = sof_cnt; vs_b = vs_hi_cnt;
        push_frame(4, 2, 0, 8'h00);
        en = 1'b1;
        tick();
        en = 1'b0;
        t = 1;
        while (!de_o && t < 50) begin
            tick();
            t++;
        end
        check("t1_latency", t, 2 + 2);
        wait_idle("t1_idle");
        check("t1_de_count", de_cnt - de_b, 8);
        check("t1_sof_count", sof_cnt - sof_b, 1);
        check("t1_vs_cycles", vs_hi_cnt - vs_b, 4 + 3 + 4);
        check("t1_q_empty", exp_q.size(), 0);

        // T2: gap of 3 after each pixel
        set_cfg(3, 1, 3, 1, 1, 0, 8'h00);
        de_b = de_cnt; vs_b = vs_hi_cnt;
        spacing_exp = 4;
        push_frame(3, 1, 0, 8'h00);
        en = 1'b1;
        tick();
        en = 1'b0;
        wait_de("t2_start");
        wait_idle("t2_idle");
        spacing_exp = 0;
        check("t2_de_count", de_cnt - de_b, 3);
        check("t2_vs_cycles", vs_hi_cnt - vs_b, 9);
        check("t2_q_empty", exp_q.size(), 0);

        // T3: wide lines, pixel value wraps past 255
        set_cfg(600, 2, 0, 2, 2, 0, 8'h00);
        de_b = de_cnt; sof_b = sof_cnt;
        push_frame(600, 2, 0, 8'h00);
        en = 1'b1;
        tick();
        en = 1'b0;
        wait_de("t3_start");
        wait_idle("t3_idle");
        check("t3_de_count", de_cnt - de_b, 1200);
        check("t3_sof_count", sof_cnt - sof_b, 1);
        check("t3_q_empty", exp_q.size(), 0);

        // T4: back-to-back frames, width change picked up at the next frame
        set_cfg(2, 3, 0, 2, 3, 1, 8'h00);
        de_b = de_cnt; sof_b = sof_cnt;
        push_frame(2, 3, 1, 8'h00);
        push_frame(3, 3, 1, 8'h00);
        en = 1'b1;
        wait_de("t4_start");
        cfg_w = 12'd3;
        t = 0;
        while (sof_cnt < sof_b + 2 && t < 2000) begin
            tick();
            t++;
        end
        check("t4_second_sof", sof_cnt - sof_b, 2);
        check("t4_vblank_gap", last_lo_run, 3);
        en = 1'b0;
        wait_idle("t4_idle");
        check("t4_de_count", de_cnt - de_b, 6 + 9);
        check("t4_q_empty", exp_q.size(), 0);

        // T5: reset mid-line, then a clean restart
        set_cfg(8, 2, 0, 2, 1, 2, 8'h00);
        push_frame(8, 2, 2, 8'h00);
        en = 1'b1;
        tick();
        en = 1'b0;
        wait_de("t5_start");
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        check("t5_rst_de", {31'd0, de_o}, 32'd0);
        check("t5_rst_hs", {31'd0, hs_o}, 32'd1);
        check("t5_rst_vs", {31'd0, vs_o}, 32'd0);
        check("t5_rst_busy", {31'd0, busy_o}, 32'd0);
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        set_cfg(3, 2, 0, 1, 0, 3, 8'hA5);
        de_b = de_cnt; sof_b = sof_cnt;
        push_frame(3, 2, 3, 8'hA5);
        en = 1'b1;
        tick();
        en = 1'b0;
        wait_de("t5_restart");
        wait_idle("t5_idle");
        check("t5_de_count", de_cnt - de_b, 6);
        check("t5_sof_count", sof_cnt - sof_b, 1);
        check("t5_q_empty", exp_q.size(), 0);

        // T6: invalid geometry never starts; en dropped mid-frame still completes it
        set_cfg(0, 2, 0, 1, 1, 0, 8'h00);
        de_b = de_cnt; busy_b = busy_cnt;
        en = 1'b1;
        repeat (20) tick();
        en = 1'b0;
        check("t6_w0_busy", busy_cnt - busy_b, 0);
        check("t6_w0_de", de_cnt - de_b, 0);
        set_cfg(2, 4, 1, 2, 2, 2, 8'h00);
        de_b = de_cnt; sof_b = sof_cnt;
        push_frame(2, 4, 2, 8'h00);
        en = 1'b1;
        wait_de("t6_start");
        en = 1'b0;
        wait_idle("t6_idle");
        check("t6_de_count", de_cnt - de_b, 8);
        check("t6_sof_count", sof_cnt - sof_b, 1);
        check("t6_q_empty", exp_q.size(), 0);
        repeat (5) tick();
        check("t6_stays_idle", {31'd0, busy_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
